csr_access_unit: RTL
====================

Name: csr_access_unit

Overview:
- Initiator side of the CSR register-file port.
- Accepts one decoded Zicsr instruction (CSRRW/RS/RC and immediate forms) from the execute stage.
- Sequences the read, privilege/legality checks, read-modify-write and single-cycle write into the CSR file, then returns the old value (for rd) or an illegal-instruction flag to the pipeline over a valid/ready handshake.

Parameters:
- PRV_CHECK, 1, 1 = enforce privilege check csr[9:8] <= prvmode; 0 = skip the check.
- XLEN, 64, data width of CSR values.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_op  in  3  funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI.
- req_csr  in  12  CSR address.
- req_src  in  XLEN  rs1 value; for immediate ops, zimm in bits [4:0].
- req_rs1_nz  in  1  rs1 field (or zimm) nonzero.
- prvmode  in  2  current privilege mode.
- csr_addr  out  12  address to CSR file.
- csr_rdata  in  XLEN  combinational read data from CSR file.
- csr_we  out  1  write enable to CSR file.
- csr_wd  out  XLEN  write data to CSR file.
- resp_valid  out  1  response present.
- resp_ready  in  1  pipeline accepts response.
- resp_rdata  out  XLEN  old CSR value (0 if illegal).
- resp_illegal  out  1  illegal-instruction exception.

Behaviour:
- Reset (async, immediate): state=IDLE; req_ready=1; csr_we=0, csr_addr=0, csr_wd=0, resp_valid=0, resp_rdata=0, resp_illegal=0; latched request cleared. Reset mid-transaction aborts with no write issued.
- States: IDLE, READ, WRITE, RESP. req_ready=1 only in IDLE.
- IDLE: on req_valid&req_ready, latch op/csr/src/rs1_nz; go to READ.
- READ (1 cycle): csr_addr=latched csr; capture csr_rdata as old. Compute:
  - wr_intent = RW/RWI always; RS/RC/RSI/RCI only when rs1_nz.
  - operand = src for register ops, zero-extended src[4:0] for immediate ops.
  - new = operand (RW*), old|operand (RS*), old&~operand (RC*).
  - illegal if any of: op is 000 or 100; address not in {0x180,0x300,0x304,0x305,0x340,0x341,0x342,0x343,0x344,0xB00,0xF14}; PRV_CHECK and csr[9:8] > prvmode; wr_intent and csr[11:10]==11.
  - Next state: WRITE if wr_intent and not illegal, else RESP.
- WRITE (1 cycle): csr_addr=latched csr, csr_we=1, csr_wd=new; go to RESP. csr_we is never high in any other state.
- RESP: resp_valid=1; resp_rdata=old (0 when illegal); resp_illegal as computed. Outputs held stable until resp_ready. On resp_valid&resp_ready go to IDLE; a new request is accepted no earlier than the following cycle.
- csr_addr=0 in IDLE and RESP.
- Latency, accept cycle N: write case csr_we at N+2, resp_valid at N+3; no-write or illegal case resp_valid at N+2.
- A new request arriving while busy is ignored; the requester holds req_valid until accepted.

Optional Feature:
- CSR_WARL_MASK_EN.
- Defined: writes to mstatus (0x300) are masked to writable fields MIE[3], MPIE[7], MPP[12:11]: csr_wd = (old & ~M) | (new & M), M = 0x1888. Writes to mtvec force csr_wd[1:0] = 0.
- Undefined: csr_wd = new, full width, for every CSR.

Test Plan:
- Reset asserted asynchronously while in WRITE -> csr_we drops to 0 the same cycle; req_ready=1; resp_valid=0.
- CSRRW 0x340, src=0xDEAD, csr_rdata=0x5 -> csr_we at N+2 with csr_wd=0xDEAD; resp at N+3 with rdata=0x5, illegal=0.
- CSRRS 0x300, rs1_nz=0, csr_rdata=0x1888 -> no csr_we; resp at N+2 with rdata=0x1888. CSRRCI 0x304, zimm=0x8, old=0xFF -> csr_wd=0xF7.
- CSRRW 0xF14 (mhartid) -> resp_illegal=1, rdata=0, no write. Op 100 -> illegal. CSR 0x7C0 -> illegal.
- prvmode=00, CSRRS 0x341 with PRV_CHECK=1 -> illegal; with PRV_CHECK=0 -> legal read.
- resp_ready held low 5 cycles -> resp_valid and resp_rdata stable and req_ready=0 throughout. With CSR_WARL_MASK_EN, CSRRW 0x300 src=all-ones, old=0 -> csr_wd=0x1888.

Source files
------------

// File: rtl/csr_access_unit.sv
// Initiator side of the CSR register-file port: sequences one Zicsr instruction through read, check, write, respond.
// Optional CSR_WARL_MASK_EN restricts mstatus writes to MIE/MPIE/MPP and clears mtvec[1:0].
module csr_access_unit #(
  parameter int PRV_CHECK = 1,
  parameter int XLEN      = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [11:0]     req_csr,
  input  logic [XLEN-1:0] req_src,
  input  logic            req_rs1_nz,
  input  logic [1:0]      prvmode,
  output logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_rdata,
  output logic            csr_we,
  output logic [XLEN-1:0] csr_wd,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_illegal
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam int NUM_CSRS = 11;
  localparam logic [11:0] LEGAL_CSRS [NUM_CSRS] = '{
    12'h180, 12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
    12'h342, 12'h343, 12'h344, 12'hB00, 12'hF14
  };

  state_t state_reg, state_next;

  logic [2:0]      op_reg;
  logic [11:0]     csr_reg;
  logic [XLEN-1:0] src_reg;
  logic            rs1_nz_reg;
  logic [XLEN-1:0] old_reg;
  logic [XLEN-1:0] wd_reg;
  logic            illegal_reg;

  logic [NUM_CSRS-1:0] addr_hit;
  logic            is_rw, is_rs, is_rc;
  logic            wr_intent;
  logic            prv_bad;
  logic            ro_bad;
  logic            illegal_now;
  logic [XLEN-1:0] operand;
  logic [XLEN-1:0] new_val;
  logic [XLEN-1:0] wd_val;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CSRS; gi++) begin : g_addr_hit
      assign addr_hit[gi] = (csr_reg == LEGAL_CSRS[gi]);
    end
  endgenerate

  // Decode of the latched request against the live read data (only consumed in READ)
  always_comb begin
    is_rw     = (op_reg[1:0] == 2'b01);
    is_rs     = (op_reg[1:0] == 2'b10);
    is_rc     = (op_reg[1:0] == 2'b11);
    wr_intent = is_rw | ((is_rs | is_rc) & rs1_nz_reg);
    operand   = op_reg[2] ? {{(XLEN-5){1'b0}}, src_reg[4:0]} : src_reg;
    if (is_rs)      new_val = csr_rdata | operand;
    else if (is_rc) new_val = csr_rdata & ~operand;
    else            new_val = operand;
    prv_bad     = (PRV_CHECK != 0) && (csr_reg[9:8] > prvmode);
    ro_bad      = wr_intent && (csr_reg[11:10] == 2'b11);
    illegal_now = (op_reg[1:0] == 2'b00) || !(|addr_hit) || prv_bad || ro_bad;
  end

`ifdef CSR_WARL_MASK_EN
  localparam logic [XLEN-1:0] MSTATUS_WR_MASK = XLEN'(16'h1888);
  always_comb begin
    wd_val = new_val;
    if (csr_reg == 12'h300)
      wd_val = (csr_rdata & ~MSTATUS_WR_MASK) | (new_val & MSTATUS_WR_MASK);
    else if (csr_reg == 12'h305)
      wd_val[1:0] = 2'b00;
  end
`else
  assign wd_val = new_val;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_valid) state_next = READ;
      READ:    state_next = (wr_intent && !illegal_now) ? WRITE : RESP;
      WRITE:   state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_reg      <= '0;
      csr_reg     <= '0;
      src_reg     <= '0;
      rs1_nz_reg  <= 1'b0;
      old_reg     <= '0;
      wd_reg      <= '0;
      illegal_reg <= 1'b0;
    end else begin
      if (state_reg == IDLE && req_valid) begin
        op_reg     <= req_op;
        csr_reg    <= req_csr;
        src_reg    <= req_src;
        rs1_nz_reg <= req_rs1_nz;
      end
      // Old value is zeroed here for illegal accesses so RESP just replays the register
      if (state_reg == READ) begin
        old_reg     <= illegal_now ? '0 : csr_rdata;
        wd_reg      <= wd_val;
        illegal_reg <= illegal_now;
      end
    end
  end

  always_comb begin
    req_ready    = 1'b0;
    csr_addr     = '0;
    csr_we       = 1'b0;
    csr_wd       = '0;
    resp_valid   = 1'b0;
    resp_rdata   = '0;
    resp_illegal = 1'b0;
    case (state_reg)
      IDLE:  req_ready = 1'b1;
      READ:  csr_addr  = csr_reg;
      WRITE: begin
        csr_addr = csr_reg;
        csr_we   = 1'b1;
        csr_wd   = wd_reg;
      end
      RESP: begin
        resp_valid   = 1'b1;
        resp_rdata   = old_reg;
        resp_illegal = illegal_reg;
      end
      default: ;
    endcase
  end

endmodule
